exe_mem_skid_reg: RTL
=====================

// Module: exe_mem_skid_reg
// PURPOSE
//  Parametrised EXE->MEM pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer.
//  Carries WB/MEM control bits, destination tag, ALU result and store data (valRm) from the EXE stage into the MEM stage.
//  A stalled MEM stage (e.g. a cache miss) back-pressures EXE without any combinational ready path, and freeze/flush are supported.
// PARAMETERS
//  DATA_W     32  width of alu_res and val_rm
//  DEST_W     4   width of the destination register tag
//  GATE_CTRL  1   1: wb_en/mem_r_en/mem_w_en outputs forced 0 whenever out_valid=0
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  freeze       in   1       global stall: no transfer on either side, all state held
//  flush        in   1       synchronous clear of all entries (branch/exception squash)
//  in_valid     in   1       EXE presents a beat
//  in_ready     out  1       register can accept a beat this cycle
//  wb_en_in     in   1       write-back enable
//  mem_r_en_in  in   1       memory read enable
//  mem_w_en_in  in   1       memory write enable
//  dest_in      in   DEST_W  destination register tag
//  alu_res_in   in   DATA_W  ALU result / memory address
//  val_rm_in    in   DATA_W  store data
//  out_valid    out  1       MEM beat valid
//  out_ready    in   1       MEM stage consumes the beat
//  wb_en_out, mem_r_en_out, mem_w_en_out, dest_out, alu_res_out, val_rm_out  out  (as inputs)  head-entry payload
//  occupancy    out  2       entries held: 0, 1 or 2
// BEHAVIOUR
//  Reset (async, rst=1): state EMPTY; both entries zeroed; out_valid=0; all payload outputs 0; occupancy=0; in_ready=0 while rst=1.
//  Accept:  acc = in_valid & in_ready.   Take: tak = out_valid & out_ready.
//  in_ready = ~rst & ~freeze & (state != FULL). It depends only on registered state and freeze, never on out_ready.
//  out_valid = (state != EMPTY) & ~freeze. The payload outputs always show the main entry.
//  FSM states: EMPTY(occ 0), BUSY(occ 1), FULL(occ 2); occupancy is encoded directly from the state.
//   EMPTY: acc -> main<=in, BUSY.
//   BUSY:  acc&tak -> main<=in, stay BUSY; acc&~tak -> skid<=in, FULL; ~acc&tak -> EMPTY; else hold.
//   FULL:  in_ready=0; tak -> main<=skid, BUSY; else hold.
//  Latency: 1 cycle from accept into an EMPTY register (or into BUSY with a take) to out_valid; throughput 1 beat/cycle.
//  Simultaneous accept and take in BUSY is legal and gives back-to-back flow with no bubble.
//  freeze=1: no acc, no tak, state and entries held; out_valid=0 and control outputs are gated per GATE_CTRL.
//  flush=1 (sync, overrides freeze/acc/tak): state->EMPTY next edge; the incoming beat is dropped; entry data is held, not zeroed.
//  GATE_CTRL=1: the three enable outputs are AND-ed with out_valid; dest/alu_res/val_rm are never gated.
//  Payload is only written on acc, or on a main<=skid move; entries never change otherwise.
//  Reset mid-transfer: all held beats are lost; the upstream must replay them.
// STRUCTURE
//  Shared package pipe_pkg: typedef enum skid_state_t {EMPTY,BUSY,FULL}; struct exe_mem_payload_t {wb_en,mem_r_en,mem_w_en,dest,alu_res,val_rm}.
//  One sub-module: pipe_payload_reg (parametrised width, ld, async rst), instantiated twice (main, skid).
//  The FSM and handshake logic live in this module.
// TESTING
//  1 Reset: rst pulse mid-stream -> out_valid=0, occupancy=0, alu_res_out=0; in_ready=1 on the first cycle after release.
//  2 Stream: out_ready=1; beats alu_res 1..8 on 8 consecutive cycles -> same 8 values out in order, 1-cycle lag, no gaps.
//  3 Back-pressure: send A=0x11, B=0x22 with out_ready=0 -> occupancy=2, in_ready=0; raise out_ready -> A then B in consecutive cycles, none lost.
//  4 Freeze: freeze=1 for 3 cycles while BUSY (dest=5, wb_en=1) -> out_valid=0, wb_en_out=0, dest_out=5; after release the beat is delivered once.
//  5 Flush: assert flush while FULL together with in_valid=1 -> next cycle occupancy=0, out_valid=0; the dropped beat never appears.
//  6 Ctrl gating: GATE_CTRL=1, EMPTY after a mem_w_en=1 beat drained -> mem_w_en_out=0 while val_rm_out retains the last value.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary types: skid FSM states, EXE->MEM payload layout and
// small helpers used by the stage registers.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_DEST_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic                   wb_en;
    logic                   mem_r_en;
    logic                   mem_w_en;
    logic [PIPE_DEST_W-1:0] dest;
    logic [PIPE_DATA_W-1:0] alu_res;
    logic [PIPE_DATA_W-1:0] val_rm;
  } exe_mem_payload_t;

  // Three enable bits, the destination tag, ALU result and store data.
  function automatic int payload_w(input int dest_w, input int data_w);
    return 3 + dest_w + 2 * data_w;
  endfunction

  function automatic logic [1:0] occ_of(input skid_state_t s);
    case (s)
      EMPTY:   return 2'd0;
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Load-enabled payload register with asynchronous active-high clear; one
// instance per skid entry.
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM boundary register with valid/ready handshake and a 2-entry skid so
// that in_ready never depends combinationally on out_ready.
//
// state | meaning
// EMPTY | no beat held, outputs show stale main entry
// BUSY  | one beat in main entry, presented to MEM
// FULL  | main presented, skid holds the next beat, upstream stalled
module exe_mem_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEST_W    = 4,
  parameter int GATE_CTRL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_rm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [1:0]        occupancy
);

  localparam int PW = payload_w(DEST_W, DATA_W);

  skid_state_t state_q, state_d;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;

  logic acc;
  logic tak;
  logic ld_main;
  logic ld_skid;
  logic main_from_skid;

  logic wb_en_q;
  logic mem_r_en_q;
  logic mem_w_en_q;
  logic en_gate;

  assign in_pl = {wb_en_in, mem_r_en_in, mem_w_en_in, dest_in, alu_res_in, val_rm_in};

  // Handshake terms come only from registered state, freeze and rst.
  assign in_ready  = ~rst & ~freeze & (state_q != FULL);
  assign out_valid = (state_q != EMPTY) & ~freeze;
  assign acc       = in_valid & in_ready;
  assign tak       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over everything; entry contents are left as they were.
  always_comb begin
    state_d        = state_q;
    ld_main        = 1'b0;
    ld_skid        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            ld_main = 1'b1;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (acc && tak) begin
            ld_main = 1'b1;
          end else if (acc) begin
            ld_skid = 1'b1;
            state_d = FULL;
          end else if (tak) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (tak) begin
            ld_main        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pl;

  pipe_payload_reg #(.W(PW)) u_main (
    .clk (clk),
    .rst (rst),
    .ld  (ld_main),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_payload_reg #(.W(PW)) u_skid (
    .clk (clk),
    .rst (rst),
    .ld  (ld_skid),
    .d   (in_pl),
    .q   (skid_q)
  );

  assign {wb_en_q, mem_r_en_q, mem_w_en_q, dest_out, alu_res_out, val_rm_out} = main_q;

  // Only the side-effecting enables are masked; data fields stay visible.
  assign en_gate      = (GATE_CTRL != 0) ? out_valid : 1'b1;
  assign wb_en_out    = wb_en_q & en_gate;
  assign mem_r_en_out = mem_r_en_q & en_gate;
  assign mem_w_en_out = mem_w_en_q & en_gate;

  assign occupancy = occ_of(state_q);

endmodule
